// File: rtl/mult_div_pkg.sv
// Shared multiplier/divider definitions: operand width, iteration counts and FSM encodings.
package mult_div_pkg;

  localparam int WIDTH      = 32;
  localparam int ITERATIONS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  // Restoring divider retires one quotient bit per cycle.
  localparam int DIV_ITERATIONS = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/booth_pair_recoder.sv
// Radix-4 Booth digit recoder: triplet {q[2i+1], q[2i], q[2i-1]} -> partial-product select.
module booth_pair_recoder (
  input  logic [2:0] triplet,
  output logic       zero,
  output logic       one,
  output logic       two,
  output logic       negate
);

  always_comb begin
    zero   = 1'b0;
    one    = 1'b0;
    two    = 1'b0;
    negate = 1'b0;
    case (triplet)
      3'b000, 3'b111: zero = 1'b1;
      3'b001, 3'b010: one  = 1'b1;
      3'b011:         two  = 1'b1;
      3'b100: begin
        two    = 1'b1;
        negate = 1'b1;
      end
      3'b101, 3'b110: begin
        one    = 1'b1;
        negate = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential signed multiplier: radix-4 Booth, one recoded digit per cycle, 64-bit product on hi/lo.
module seq_booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mult_div_pkg::*;

  localparam int ACC_W = 2 * WIDTH + 2;
  localparam int PP_W  = WIDTH + 2;

  mult_state_e      state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [4:0]       count_q, count_d;
  logic             done_q, done_d;

  logic [WIDTH:0]          q_ext;
  logic [2:0]              triplet;
  logic                    pp_zero, pp_one, pp_two, pp_neg;
  logic [PP_W-1:0]         m_ext, pp_mag, pp, sum_hi;
  logic signed [ACC_W-1:0] acc_step;

  // q[-1] is the appended zero; the counter walks the overlapping triplets.
  assign q_ext   = {q_q, 1'b0};
  assign triplet = q_ext[{count_q[3:0], 1'b0} +: 3];

  booth_pair_recoder u_recoder (
    .triplet (triplet),
    .zero    (pp_zero),
    .one     (pp_one),
    .two     (pp_two),
    .negate  (pp_neg)
  );

  // Two guard bits keep 2*M and -2*M exact for M = -2^(WIDTH-1).
  always_comb begin
    m_ext    = {{2{m_q[WIDTH-1]}}, m_q};
    pp_mag   = pp_two ? (m_ext << 1) : (pp_one ? m_ext : '0);
    pp       = pp_zero ? '0 : (pp_neg ? (~pp_mag + 1'b1) : pp_mag);
    sum_hi   = acc_q[ACC_W-1:WIDTH] + pp;
    acc_step = $signed({sum_hi, acc_q[WIDTH-1:0]}) >>> 2;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (count_q == 5'(ITERATIONS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  always_comb begin
    m_d     = m_q;
    q_d     = q_q;
    acc_d   = acc_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          acc_d   = '0;
          count_d = '0;
        end
      end
      CALC: begin
        acc_d   = acc_step;
        count_d = count_q + 5'd1;
      end
      DONE: begin
        hi_d   = acc_q[2*WIDTH-1:WIDTH];
        lo_d   = acc_q[WIDTH-1:0];
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      m_q     <= m_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Self-checking bench: cycle-level latency model plus 64-bit reference product, directed and random.
module tb_seq_booth_multiplier;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  wire         busy;
  wire         done;
  wire  [31:0] hi;
  wire  [31:0] lo;

  int errors = 0;
  int checks = 0;

  seq_booth_multiplier #(.WIDTH(32)) dut (
    .clock        (clock),
    .clear        (clear),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  // Reference: accepted start -> busy for 16 cycles, one quiet cycle, then a done cycle with the product.
  bit          m_active = 1'b0;
  int          m_k = 0;
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [63:0] m_res = '0;
  logic [63:0] m_pending = '0;
  bit          model_on = 1'b0;

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      m_active = 1'b0;
      m_k      = 0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_res    = '0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_k++;
        m_busy = (m_k < 16);
        if (m_k == 17) begin
          m_done   = 1'b1;
          m_res    = m_pending;
          m_active = 1'b0;
        end
      end else if (start) begin
        m_active  = 1'b1;
        m_k       = 0;
        m_busy    = 1'b1;
        m_pending = product(multiplicand, multiplier);
      end
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      chk("busy", {63'b0, busy}, {63'b0, m_busy});
      chk("done", {63'b0, done}, {63'b0, m_done});
      chk("hi",   {32'b0, hi}, {32'b0, m_res[63:32]});
      chk("lo",   {32'b0, lo}, {32'b0, m_res[31:0]});
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit stray, output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    @(posedge clock); #1;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clock); #1;
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (done) begin
        got = 1'b1;
        lat = i;
      end else if (stray && i < 14) begin
        start = ($urandom_range(0, 3) == 0);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [5];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 5) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int pulses;
    clear        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    chk("pin_m7q3",    product(32'd7, 32'd3), 64'h0000_0000_0000_0015);
    chk("pin_mneg7q3", product(32'hFFFF_FFF9, 32'd3), 64'hFFFF_FFFF_FFFF_FFEB);

    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    model_on = 1'b1;
    @(negedge clock);
    clear = 1'b0;

    do_op(32'd7, 32'd3, 1'b0, lat);
    chk("lat_7x3", lat, 17);
    chk("hilo_7x3", {hi, lo}, 64'h0000_0000_0000_0015);

    do_op(32'hFFFF_FFF9, 32'd3, 1'b0, lat);
    chk("hilo_m7x3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, lat);
    chk("hilo_minxmin", {hi, lo}, 64'h4000_0000_0000_0000);

    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    chk("hilo_m1xm1", {hi, lo}, 64'h0000_0000_0000_0001);

    // Second start five cycles into the computation must be dropped.
    @(posedge clock); #1;
    multiplicand = 32'd1234;
    multiplier   = 32'hFFFF_FFFB;
    start        = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    multiplicand = 32'd99;
    multiplier   = 32'd99;
    start        = 1'b1;
    @(posedge clock); #1;
    start  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (done) pulses++;
    end
    chk("restart_pulses", pulses, 1);
    chk("restart_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_E7E6);

    // Clear at CALC cycle 8 wipes outputs immediately; the next start still works.
    @(posedge clock); #1;
    multiplicand = 32'd100;
    multiplier   = 32'd200;
    start        = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    chk("busy_before_clear", {63'b0, busy}, 64'd1);
    clear = 1'b1;
    #1;
    chk("clr_busy", {63'b0, busy}, 64'd0);
    chk("clr_done", {63'b0, done}, 64'd0);
    chk("clr_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clock);
    clear = 1'b0;
    do_op(32'hFFFF_FFFD, 32'd11, 1'b0, lat);
    chk("lat_after_clear", lat, 17);
    chk("hilo_after_clear", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFDF);

    for (int n = 0; n < 1000; n++) begin
      do_op(pick(), pick(), ($urandom_range(0, 3) == 0), lat);
      chk("rand_lat", lat, 17);
    end

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_booth_multiplier.md
SEQ_BOOTH_MULTIPLIER -- requirements
Module: seq_booth_multiplier

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: clear  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: start  input  1  request; sampled on a rising edge while IDLE.
REQ-004 SHALL have port: multiplicand  input  32  signed two's-complement operand M.
REQ-005 SHALL have port: multiplier  input  32  signed two's-complement operand Q.
REQ-006 SHALL have port: busy  output  1  high while in CALC.
REQ-007 SHALL have port: done  output  1  one-cycle pulse; hi/lo valid.
REQ-008 SHALL have port: hi  output  32  product bits [63:32].
REQ-009 SHALL have port: lo  output  32  product bits [31:0].
REQ-010 SHALL have parameter: WIDTH, default 32, operand width; only 32 is supported.

Function
REQ-011 SHALL compute the full signed 64-bit product M*Q with no overflow or truncation.
REQ-012 SHALL use radix-4 bit-pair (Booth) recoding of the triplets {Q[2i+1], Q[2i], Q[2i-1]}, with Q[-1]=0, over 16 iterations.
REQ-013 SHALL select partial products from {0, +M, +2M, -M, -2M}, sign-extended to 34 bits so that 2*(-2^31) is exact.
REQ-014 SHALL implement states IDLE, CALC, DONE.
REQ-015 SHALL, in IDLE with start=1 at an edge, register M and Q, clear the accumulator and iteration count, and go to CALC.
REQ-016 SHALL, in CALC, retire one recoded digit per edge (accumulator add, arithmetic right shift by 2), then go to DONE on the 16th edge.
REQ-017 SHALL, in DONE, load hi/lo from the accumulator, assert done for exactly one cycle, then return to IDLE on the next edge.
REQ-018 SHALL have latency: start sampled at edge N -> done high in the cycle following edge N+17; next start accepted at edge N+18.
REQ-019 SHALL ignore start while in CALC or DONE; no queuing and no effect on the result in progress.
REQ-020 SHALL ignore operand changes after the start edge.
REQ-021 SHALL hold hi/lo at the last result until the next DONE; they SHALL NOT change during CALC.
REQ-022 SHALL keep busy=0 and done=0 in IDLE, and keep busy and done mutually exclusive.

Reset
REQ-023 SHALL, while clear=1, immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, and clear the iteration count and accumulator.
REQ-024 SHALL, when clear asserts mid-operation, abandon the computation with no done pulse; start is honoured on the first edge after clear deasserts.

Structure
REQ-025 SHALL place state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2), WIDTH=32 and ITERATIONS=16 in the shared mult_div definitions package/include alongside the divider constants.
REQ-026 SHALL instantiate one sub-module, booth_pair_recoder: combinational, 3-bit triplet -> select {zero, one, two, negate}.
REQ-027 SHALL be synthesizable: no initial blocks, no variable-bound loops; a single 66-bit accumulator plus a 5-bit counter.

Verification
REQ-028 SHALL cover: M=7, Q=3, start pulse -> done at start+17 cycles, hi=0x00000000, lo=0x00000015.
REQ-029 SHALL cover: M=-7 (0xFFFFFFF9), Q=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-030 SHALL cover: M=Q=0x80000000 -> hi=0x40000000, lo=0x00000000; and M=Q=0xFFFFFFFF -> hi=0x00000000, lo=0x00000001.
REQ-031 SHALL cover: start re-pulsed with new operands 5 cycles into CALC -> ignored; first result unchanged; exactly one done pulse.
REQ-032 SHALL cover: clear asserted at CALC cycle 8 -> busy, done, hi and lo all 0 at once; a new start after release gives a correct product.
REQ-033 SHALL cover: 1000 random signed operand pairs checked against a 64-bit reference product, including 0 and ±1 corners.
